bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin_pkg.sv | 13 +
 rtl/bcd_mul10_add.sv | 13 +
 rtl/bcd_to_bin.sv | 98 +++++++++
 tb/tb_bcd_to_bin.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared state enum and defaults for the BCD to binary converter
package bcd_to_bin_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam int DIGITS_DEF    = 6;
   localparam int BIN_W_DEF     = 20;
   localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_mul10_add.sv
// rtl/bcd_mul10_add.sv - combinational acc*10 + digit, wrapping modulo 2^BIN_W
module bcd_mul10_add #(
   parameter int BIN_W = 20
) (
   input  logic [BIN_W-1:0] acc,
   input  logic [3:0]       digit,
   output logic [BIN_W-1:0] result
);

   // Shift-add keeps the multiply cheap; every term is BIN_W wide so overflow wraps.
   assign result = (acc << 3) + (acc << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - serial MSD-first BCD to binary converter; optional BCD_DIGIT_CHECK_EN flags digits >9
module bcd_to_bin
   import bcd_to_bin_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] BCD_in,
   output logic [BIN_W-1:0]    bin_out,
   output logic                done,
   output logic                busy,
   output logic                err
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state;
   logic [4*DIGITS-1:0] shreg;
   logic [BIN_W-1:0]    acc;
   logic [BIN_W-1:0]    acc_next;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          digit;
   logic                last_step;

   assign digit     = shreg[4*DIGITS-1 -: 4];
   assign last_step = (cnt == CNT_W'(DIGITS - 1));

   bcd_mul10_add #(.BIN_W(BIN_W)) u_mul10_add (
      .acc    (acc),
      .digit  (digit),
      .result (acc_next)
   );

`ifdef BCD_DIGIT_CHECK_EN
   logic bad;
   logic bad_now;
   // Include the digit being consumed this edge so the last nibble is also caught.
   assign bad_now = bad | (digit > 4'(BCD_MAX_DIGIT));
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         bin_out <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         bad     <= 1'b0;
         err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= BCD_in;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
`ifdef BCD_DIGIT_CHECK_EN
                  bad   <= 1'b0;
`endif
               end
            end
            CONV: begin
               acc   <= acc_next;
               shreg <= shreg << 4;
               cnt   <= cnt + CNT_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
               bad   <= bad_now;
`endif
               if (last_step) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                  bin_out <= bad_now ? '0 : acc_next;
                  err     <= bad_now;
`else
                  bin_out <= acc_next;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed and randomized checks of bcd_to_bin against an arithmetic reference
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [23:0] BCD_in;
   logic [19:0] bin_out;
   logic        done;
   logic        busy;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bcd_to_bin dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .BCD_in  (BCD_in),
      .bin_out (bin_out),
      .done    (done),
      .busy    (busy),
      .err     (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic has_bad_digit(input logic [23:0] op);
      logic bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [3:0] d = op[i*4 +: 4];
         if (d > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Decimal evaluation of the nibbles, wrapped to 20 bits.
   function automatic logic [19:0] ref_bin(input logic [23:0] op);
      longint unsigned v = 0;
      for (int i = 5; i >= 0; i--) begin
         longint unsigned d = longint'(op[i*4 +: 4]);
         v = (v * 10 + d) % (64'd1 << 20);
      end
`ifdef BCD_DIGIT_CHECK_EN
      if (has_bad_digit(op)) v = 0;
`endif
      return v[19:0];
   endfunction

   function automatic logic ref_err(input logic [23:0] op);
`ifdef BCD_DIGIT_CHECK_EN
      return has_bad_digit(op);
`else
      return (op == 24'hFFFFFF) && 1'b0;
`endif
   endfunction

   function automatic logic [23:0] rand_op(input bit allow_bad);
      logic [23:0] op;
      for (int i = 0; i < 6; i++)
         op[i*4 +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      return op;
   endfunction

   // Drive start for one capture edge; returns #1 after that edge.
   task automatic launch(input logic [23:0] op);
      @(negedge clk);
      start  = 1'b1;
      BCD_in = op;
      @(posedge clk);
      #1;
      check("busy_after_capture", 32'(busy), 32'd1);
   endtask

   // Called #1 after the capture edge (plus 'already' edges); scrambles BCD_in and waits for done.
   task automatic wait_result(input logic [23:0] op, input int already,
                              input bit chain, input logic [23:0] next_op);
      int edges    = already;
      int busy_cnt = already + 1;
      start  = 1'b0;
      BCD_in = 24'($urandom);
      while (!done && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
         BCD_in = 24'($urandom);
         if (busy) busy_cnt++;
      end
      check("latency_edges", 32'(edges), 32'd6);
      check("busy_cycles", 32'(busy_cnt), 32'd6);
      check("bin_out", 32'(bin_out), 32'(ref_bin(op)));
      check("err", 32'(err), 32'(ref_err(op)));
      if (chain) begin
         start  = 1'b1;
         BCD_in = next_op;
         @(posedge clk);
         #1;
         check("done_single_pulse", 32'(done), 32'd0);
         check("busy_chained", 32'(busy), 32'd1);
      end else begin
         @(posedge clk);
         #1;
         check("done_single_pulse", 32'(done), 32'd0);
         check("bin_out_held", 32'(bin_out), 32'(ref_bin(op)));
         check("err_held", 32'(err), 32'(ref_err(op)));
      end
   endtask

   initial begin
      logic [23:0] a;
      logic [23:0] b;
      int          done_seen;

      rst_n  = 1'b0;
      start  = 1'b0;
      BCD_in = 24'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_bin_out", 32'(bin_out), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(24'h123456);
      wait_result(24'h123456, 0, 1'b0, 24'h0);
      check("const_123456", 32'(bin_out), 32'h1E240);

      launch(24'h999999);
      wait_result(24'h999999, 0, 1'b0, 24'h0);
      check("const_999999", 32'(bin_out), 32'hF423F);
      launch(24'h000000);
      wait_result(24'h000000, 0, 1'b0, 24'h0);
      check("const_zero", 32'(bin_out), 32'd0);

      launch(24'h12A456);
      wait_result(24'h12A456, 0, 1'b0, 24'h0);

      // Start raised mid-conversion must be ignored.
      a = 24'h314159;
      b = 24'h271828;
      launch(a);
      start  = 1'b0;
      BCD_in = b;
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      wait_result(a, 2, 1'b0, 24'h0);
      done_seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("ignored_start_no_done", 32'(done_seen), 32'd0);

      // Reset in the third CONV cycle aborts the conversion.
      launch(24'h987654);
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("busy_before_abort", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_bin_out", 32'(bin_out), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      launch(24'h000042);
      wait_result(24'h000042, 0, 1'b0, 24'h0);

      // Back-to-back conversions with start raised during done.
      a = 24'h555555;
      b = 24'h010203;
      launch(a);
      wait_result(a, 0, 1'b1, b);
      wait_result(b, 0, 1'b0, 24'h0);

      for (int n = 0; n < 24; n++) begin
         a = rand_op(n % 3 == 0);
         b = rand_op(n % 4 == 1);
         launch(a);
         if (n % 2 == 0) begin
            wait_result(a, 0, 1'b1, b);
            wait_result(b, 0, 1'b0, 24'h0);
         end else begin
            wait_result(a, 0, 1'b0, 24'h0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
